fire_alarm_ctrl: RTL and testbench

- Multi-zone successor to the single-sensor combinational fire alarm.
- Monitors NUM_SENSORS smoke-level channels and requires a persistent over-threshold reading before tripping, which filters glitches.
- Latches the alarm until it is acknowledged and all zones are clear, uses hysteresis to clear, and drives a pulsed siren.
- Sits between the sensor front-end and the home annunciator/siren driver.

---
 rtl/fire_alarm_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fire_alarm_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_alarm_ctrl.sv
// fire_alarm_ctrl: multi-zone smoke alarm controller.
// Each channel must read over TRIP_TH for PERSIST consecutive cycles to trip
// its zone. The alarm latches until it is acknowledged and every channel has
// read under CLEAR_TH for PERSIST consecutive cycles. Readings between the
// two thresholds hold the current condition (hysteresis band). While the
// alarm is active and unacknowledged, the siren toggles every SIREN_HALF
// cycles, starting high.
// Optional build macro FIRE_ALARM_SELFTEST_EN adds a test_req input that
// forces IDLE -> ALARM without tripping any zone.
module fire_alarm_ctrl #(
    parameter int NUM_SENSORS = 4,
    parameter int DATA_W      = 8,
    parameter int TRIP_TH     = 5,
    parameter int CLEAR_TH    = 3,
    parameter int PERSIST     = 4,
    parameter int SIREN_HALF  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SENSORS*DATA_W-1:0] smoke,
    input  logic                          ack,
`ifdef FIRE_ALARM_SELFTEST_EN
    input  logic                          test_req,
`endif
    output logic                          alarmEnable,
    output logic                          siren,
    output logic                          pre_alarm,
    output logic [NUM_SENSORS-1:0]        zone,
    output logic [2:0]                    state
);

    localparam int CNT_W = $clog2(PERSIST + 1);
    localparam int SIR_W = $clog2(SIREN_HALF + 1);

    localparam logic [CNT_W-1:0]  P_MAX  = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0]  P_M1   = CNT_W'(PERSIST - 1);
    localparam logic [SIR_W-1:0]  SH_M1  = SIR_W'(SIREN_HALF - 1);
    localparam logic [DATA_W-1:0] TRIP_V = DATA_W'(TRIP_TH);
    localparam logic [DATA_W-1:0] CLR_V  = DATA_W'(CLEAR_TH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE      = 3'd1,
        ALARM    = 3'd2,
        SILENCED = 3'd3
    } state_t;

    state_t                 cur_st;
    state_t                 nxt_st;
    logic [CNT_W-1:0]       cnt [NUM_SENSORS];
    logic [CNT_W-1:0]       clr_cnt;
    logic [SIR_W-1:0]       sir_cnt;
    logic                   siren_q;
    logic [NUM_SENSORS-1:0] zone_q;
    logic [NUM_SENSORS-1:0] over;
    logic [NUM_SENSORS-1:0] under;
    logic [NUM_SENSORS-1:0] trip;
    logic                   all_under;
    logic                   all_clear;
    logic                   new_trip;
    logic                   self_test;
    logic                   enter_alarm;
    logic                   enter_idle;

    // Persistence counters stop at PERSIST so a long run cannot wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == P_MAX) ? v : v + CNT_W'(1);
    endfunction

`ifdef FIRE_ALARM_SELFTEST_EN
    assign self_test = test_req;
`else
    assign self_test = 1'b0;
`endif

    // Classify each reading against the trip/clear thresholds and derive trips.
    always_comb begin
        over  = '0;
        under = '0;
        trip  = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            over[i]  = smoke[i*DATA_W +: DATA_W] >= TRIP_V;
            under[i] = smoke[i*DATA_W +: DATA_W] <  CLR_V;
            trip[i]  = (over[i] && (cnt[i] == P_M1)) || (cnt[i] == P_MAX);
        end
    end

    assign all_under = &under;
    assign all_clear = all_under && (clr_cnt >= P_M1);
    assign new_trip  = |(trip & ~zone_q);

    // Next-state selection; ack outside ALARM has no effect.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE: begin
                if ((|trip) || self_test) nxt_st = ALARM;
                else if (|over)           nxt_st = PRE;
            end
            PRE: begin
                if (|trip)       nxt_st = ALARM;
                else if (!(|over)) nxt_st = IDLE;
            end
            ALARM: begin
                if (ack) nxt_st = SILENCED;
            end
            SILENCED: begin
                if (new_trip)       nxt_st = ALARM;
                else if (all_clear) nxt_st = IDLE;
            end
            default: nxt_st = IDLE;
        endcase
    end

    assign enter_alarm = (nxt_st == ALARM) && (cur_st != ALARM);
    assign enter_idle  = (nxt_st == IDLE)  && (cur_st != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_st <= IDLE;
        else        cur_st <= nxt_st;
    end

    // Per-channel over-run counters and the all-under run counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SENSORS; i++) cnt[i] <= '0;
            clr_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++)
                cnt[i] <= over[i] ? sat_inc(cnt[i]) : '0;
            clr_cnt <= all_under ? sat_inc(clr_cnt) : '0;
        end
    end

    // Sticky zone flags; only a return to IDLE wipes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          zone_q <= '0;
        else if (enter_idle) zone_q <= '0;
        else                 zone_q <= zone_q | trip;
    end

    // Siren pattern generator, restarted high on every entry into ALARM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            siren_q <= 1'b0;
            sir_cnt <= '0;
        end else if (enter_alarm) begin
            siren_q <= 1'b1;
            sir_cnt <= '0;
        end else if (nxt_st == ALARM) begin
            if (sir_cnt == SH_M1) begin
                siren_q <= ~siren_q;
                sir_cnt <= '0;
            end else begin
                sir_cnt <= sir_cnt + SIR_W'(1);
            end
        end else begin
            siren_q <= 1'b0;
            sir_cnt <= '0;
        end
    end

    assign alarmEnable = (cur_st == ALARM) || (cur_st == SILENCED);
    assign siren       = siren_q && (cur_st == ALARM);
    assign pre_alarm   = (cur_st == PRE);
    assign zone        = zone_q;
    assign state       = cur_st;

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Bench for fire_alarm_ctrl: directed scenarios with literal expectations,
// plus a run-length based reference model checked every cycle.
module tb_fire_alarm_ctrl;

    localparam int NS  = 4;
    localparam int DW  = 8;
    localparam int TTH = 5;
    localparam int CTH = 3;
    localparam int P   = 4;
    localparam int SH  = 2;

    logic             clk;
    logic             rst_n;
    logic [NS*DW-1:0] smoke;
    logic             ack;
    logic             test_req;
    logic             alarmEnable;
    logic             siren;
    logic             pre_alarm;
    logic [NS-1:0]    zone;
    logic [2:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    fire_alarm_ctrl #(
        .NUM_SENSORS(NS), .DATA_W(DW), .TRIP_TH(TTH),
        .CLEAR_TH(CTH), .PERSIST(P), .SIREN_HALF(SH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .smoke(smoke),
        .ack(ack),
`ifdef FIRE_ALARM_SELFTEST_EN
        .test_req(test_req),
`endif
        .alarmEnable(alarmEnable),
        .siren(siren),
        .pre_alarm(pre_alarm),
        .zone(zone),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from run lengths: how many consecutive edges each channel has
    // been over, and how many consecutive edges every channel was under.
    int            run_over [NS];
    int            run_under;
    int            m_mode;      // 0 idle, 1 pre, 2 alarm, 3 silenced
    int            m_age;       // edges since entering alarm
    logic [NS-1:0] m_zone;
    logic [NS-1:0] m_over;
    logic [NS-1:0] m_trip;
    logic          m_all_under;
    logic          m_all_clear;
    int            m_nxt;
    int            m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_age = 0; m_zone = '0; run_under = 0;
            for (int i = 0; i < NS; i++) run_over[i] = 0;
        end else begin
            m_all_under = 1'b1;
            for (int i = 0; i < NS; i++) begin
                m_rd      = int'(smoke[i*DW +: DW]);
                m_over[i] = (m_rd >= TTH);
                if (m_rd >= CTH) m_all_under = 1'b0;
                m_trip[i] = (run_over[i] >= P) || (m_over[i] && (run_over[i] + 1 >= P));
            end
            m_all_clear = m_all_under && (run_under + 1 >= P);
            m_nxt = m_mode;
            case (m_mode)
                0: if ((|m_trip) || test_req) m_nxt = 2; else if (|m_over) m_nxt = 1;
                1: if (|m_trip) m_nxt = 2; else if (m_over == '0) m_nxt = 0;
                2: if (ack) m_nxt = 3;
                default: if (|(m_trip & ~m_zone)) m_nxt = 2; else if (m_all_clear) m_nxt = 0;
            endcase
            if (m_nxt == 0 && m_mode != 0) m_zone = '0;
            else                           m_zone = m_zone | m_trip;
            if (m_nxt == 2 && m_mode != 2) m_age = 0;
            else if (m_nxt == 2)           m_age = m_age + 1;
            m_mode = m_nxt;
            for (int i = 0; i < NS; i++)
                run_over[i] = m_over[i] ? ((run_over[i] < 1000) ? run_over[i] + 1 : 1000) : 0;
            run_under = m_all_under ? ((run_under < 1000) ? run_under + 1 : 1000) : 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("state",       int'(state),       m_mode);
        chk("alarmEnable", int'(alarmEnable), (m_mode == 2 || m_mode == 3) ? 1 : 0);
        chk("pre_alarm",   int'(pre_alarm),   (m_mode == 1) ? 1 : 0);
        chk("siren",       int'(siren),       (m_mode == 2 && ((m_age / SH) % 2 == 0)) ? 1 : 0);
        chk("zone",        int'(zone),        int'(m_zone));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input int val);
        smoke[ch*DW +: DW] = DW'(val);
    endtask

    initial begin
        int exp_s [4];
        exp_s = '{1, 0, 0, 1};
        rst_n = 1'b0; ack = 1'b0; smoke = '0; test_req = 1'b0;
        tick(2);
        chk("rst_state", int'(state), 0);
        chk("rst_alarm", int'(alarmEnable), 0);
        chk("rst_zone",  int'(zone), 0);
        rst_n = 1'b1;
        tick(2);

        // Ramp ch0 up then down, two cycles per step; alarm latches.
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 2; k++) begin
                set_ch(0, v);
                tick();
                if (v == 5 && k == 0) begin
                    chk("ramp_pre_at5", int'(pre_alarm), 1);
                    chk("ramp_noalarm_edge1", int'(alarmEnable), 0);
                end
                if (v == 6 && k == 0) chk("ramp_noalarm_edge3", int'(alarmEnable), 0);
                if (v == 6 && k == 1) begin
                    chk("ramp_alarm_edge4", int'(alarmEnable), 1);
                    chk("ramp_siren_entry", int'(siren), 1);
                end
            end
        end
        for (int v = 7; v >= 0; v--) begin
            set_ch(0, v);
            tick(2);
        end
        chk("ramp_latched", int'(alarmEnable), 1);
        chk("ramp_zone", int'(zone), 4'b0001);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ramp_ack_silenced", int'(state), 3);
        tick();
        chk("ramp_back_idle", int'(state), 0);
        chk("ramp_zone_cleared", int'(zone), 0);

        // Short glitch on ch2: pre-alarm only.
        set_ch(2, 6);
        tick();
        chk("glitch_pre", int'(pre_alarm), 1);
        tick(2);
        chk("glitch_noalarm", int'(alarmEnable), 0);
        set_ch(2, 0);
        tick();
        chk("glitch_idle", int'(state), 0);
        chk("glitch_zone", int'(zone), 0);

        // Trip ch1, acknowledge, sit in the band, then clear.
        set_ch(1, 7);
        tick(4);
        chk("ch1_alarm", int'(state), 2);
        chk("ch1_zone", int'(zone), 4'b0010);
        ack = 1'b1; set_ch(1, 4); tick(); ack = 1'b0;
        chk("ch1_silenced", int'(state), 3);
        chk("ch1_siren_off", int'(siren), 0);
        tick(10);
        chk("band_hold_state", int'(state), 3);
        chk("band_hold_alarm", int'(alarmEnable), 1);
        set_ch(1, 2);
        tick(3);
        chk("clear_edge3_silenced", int'(state), 3);
        tick();
        chk("clear_edge4_idle", int'(state), 0);
        chk("clear_zone", int'(zone), 0);

        // Re-arm from SILENCED by a new zone.
        set_ch(1, 7);
        tick(4);
        ack = 1'b1; set_ch(1, 4); tick(); ack = 1'b0;
        chk("rearm_silenced", int'(state), 3);
        set_ch(3, 6);
        tick(3);
        chk("rearm_edge3", int'(state), 3);
        tick();
        chk("rearm_alarm", int'(state), 2);
        chk("rearm_zone", int'(zone), 4'b1010);
        chk("rearm_siren0", int'(siren), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rearm_siren_seq", int'(siren), exp_s[k]);
        end

        // Ack and a new-zone trip on the same edge: silenced, no re-arm.
        set_ch(0, 7);
        tick(3);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("simul_silenced", int'(state), 3);
        chk("simul_zone", int'(zone), 4'b1011);
        tick();
        chk("simul_no_rearm", int'(state), 3);
        smoke = '0;
        tick(4);
        chk("simul_idle", int'(state), 0);

        // Asynchronous reset in the middle of an alarm.
        set_ch(0, 7);
        tick(4);
        chk("pre_reset_alarm", int'(alarmEnable), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_alarm", int'(alarmEnable), 0);
        chk("async_rst_siren", int'(siren), 0);
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_zone",  int'(zone), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_edge3", int'(alarmEnable), 0);
        chk("post_rst_pre", int'(pre_alarm), 1);
        tick();
        chk("post_rst_edge4", int'(alarmEnable), 1);
        ack = 1'b1; smoke = '0; tick(); ack = 1'b0;
        tick(4);
        chk("final_idle", int'(state), 0);

`ifdef FIRE_ALARM_SELFTEST_EN
        // Self-test: forced alarm without a zone, exit by ack then all-clear.
        set_ch(0, 4);
        test_req = 1'b1; tick(); test_req = 1'b0;
        chk("st_alarm", int'(state), 2);
        chk("st_zone", int'(zone), 0);
        chk("st_siren", int'(siren), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("st_silenced", int'(state), 3);
        smoke = '0;
        tick(3);
        chk("st_edge3", int'(state), 3);
        tick();
        chk("st_idle", int'(state), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
